fir_mac_scheduler: RTL and testbench

- Sequences one shared multiply-accumulate unit across both audio channels and all FIR filters in the audio processing chain.
- Sits between the I2S-to-PCM converter valid strobes and the FIR coefficient/delay-line RAMs plus MAC.
- Queues left/right sample jobs, writes each new sample into its channel delay line, then walks taps × filters, issuing addresses and MAC controls.
- Strobes per-channel output valid when all filters for that sample are accumulated.

---
 rtl/audio_sched_pkg.sv | 21 ++
 rtl/fir_dl_pointer.sv | 27 ++
 rtl/fir_mac_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// Shared FSM encoding, channel codes and default sizing for the FIR MAC scheduler.
// Pure declarations; no logic, no latency, no flow control.
package audio_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  localparam logic CHNL_L = 1'b0;
  localparam logic CHNL_R = 1'b1;

  localparam int DEF_NUM_FILTERS = 4;
  localparam int DEF_TAP_AW      = 8;
  localparam int DEF_MAC_LATENCY = 2;

endpackage

// File: rtl/fir_dl_pointer.sv
// Per-channel wrapping delay-line write pointer; updates one cycle after i_inc.
// No backpressure: clear wins over increment.
module fir_dl_pointer #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares one MAC over both channels and all filters; job = 2 + NUM_FILTERS*(taps+MAC_LATENCY+1) cycles.
// Strobes are never stalled: repeats merge into the pending flag and raise sticky overrun. Optional FIR_SCHED_PERF_EN.
module fir_mac_scheduler
  import audio_sched_pkg::*;
#(
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int TAP_AW      = DEF_TAP_AW,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_audio_en,
  input  logic [TAP_AW-1:0] i_taps_per_filter,
  input  logic              i_l_data_en,
  input  logic              i_r_data_en,
  output logic              o_chnl_sel,
  output logic              o_sample_wr,
  output logic [TAP_AW-1:0] o_dl_addr,
  output logic [FW+TAP_AW-1:0] o_coef_addr,
  output logic              o_mac_clr,
  output logic              o_mac_en,
  output logic              o_acc_capture,
  output logic [FW-1:0]     o_filter_idx,
  output logic              o_l_data_valid,
  output logic              o_r_data_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [15:0]       o_max_job_cycles
);

  sched_state_e      r_state, w_next;
  logic              r_l_pend, r_r_pend, r_chnl, r_overrun;
  logic [TAP_AW-1:0] r_taps_q, r_tap;
  logic [FW-1:0]     r_filt;
  logic [DW-1:0]     r_drain;
  logic [TAP_AW-1:0] w_l_ptr, w_r_ptr, w_ptr;
  logic              w_start, w_start_chnl, w_tap_last, w_drain_last, w_filt_last;
  logic              w_l_serv, w_r_serv;

  // DONE arbitrates like IDLE so a queued channel loads on the very next cycle.
  assign w_start      = ((r_state == IDLE) || (r_state == DONE)) && (r_l_pend || r_r_pend);
  assign w_start_chnl = r_l_pend ? CHNL_L : CHNL_R;
  assign w_tap_last   = (r_tap == r_taps_q - TAP_AW'(1));
  assign w_drain_last = (r_drain == DW'(MAC_LATENCY - 1));
  assign w_filt_last  = (r_filt == FW'(NUM_FILTERS - 1));
  assign w_l_serv     = (r_state != IDLE) && (r_chnl == CHNL_L);
  assign w_r_serv     = (r_state != IDLE) && (r_chnl == CHNL_R);
  assign w_ptr        = (r_chnl == CHNL_R) ? w_r_ptr : w_l_ptr;

  fir_dl_pointer #(.AW(TAP_AW)) u_l_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!i_audio_en),
    .i_inc   ((r_state == LOAD) && (r_chnl == CHNL_L)),
    .o_ptr   (w_l_ptr)
  );

  fir_dl_pointer #(.AW(TAP_AW)) u_r_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!i_audio_en),
    .i_inc   ((r_state == LOAD) && (r_chnl == CHNL_R)),
    .o_ptr   (w_r_ptr)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = LOAD;
      LOAD:    w_next = MAC;
      MAC:     if (w_tap_last) w_next = DRAIN;
      DRAIN:   if (w_drain_last) w_next = STORE;
      STORE:   w_next = w_filt_last ? DONE : MAC;
      DONE:    w_next = w_start ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
    if (!i_audio_en) w_next = IDLE;
  end

  always_comb begin
    o_chnl_sel     = 1'b0;
    o_sample_wr    = 1'b0;
    o_dl_addr      = '0;
    o_coef_addr    = '0;
    o_mac_clr      = 1'b0;
    o_mac_en       = 1'b0;
    o_acc_capture  = 1'b0;
    o_filter_idx   = '0;
    o_l_data_valid = 1'b0;
    o_r_data_valid = 1'b0;
    o_busy         = 1'b0;
    o_overrun      = 1'b0;
    if (i_audio_en) begin
      o_overrun = r_overrun;
      if (r_state != IDLE) begin
        o_busy       = 1'b1;
        o_chnl_sel   = r_chnl;
        o_filter_idx = r_filt;
      end
      case (r_state)
        LOAD: begin
          o_sample_wr = 1'b1;
          o_dl_addr   = w_ptr + TAP_AW'(1);
        end
        MAC: begin
          o_mac_en    = 1'b1;
          o_mac_clr   = (r_tap == '0);
          o_dl_addr   = w_ptr - r_tap;
          o_coef_addr = {r_filt, r_tap};
        end
        STORE:   o_acc_capture = 1'b1;
        DONE: begin
          o_l_data_valid = (r_chnl == CHNL_L);
          o_r_data_valid = (r_chnl == CHNL_R);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_l_pend  <= 1'b0;
      r_r_pend  <= 1'b0;
      r_chnl    <= CHNL_L;
      r_overrun <= 1'b0;
      r_taps_q  <= TAP_AW'(1);
      r_tap     <= '0;
      r_filt    <= '0;
      r_drain   <= '0;
    end else if (!i_audio_en) begin
      r_l_pend  <= 1'b0;
      r_r_pend  <= 1'b0;
      r_chnl    <= CHNL_L;
      r_overrun <= 1'b0;
      r_taps_q  <= TAP_AW'(1);
      r_tap     <= '0;
      r_filt    <= '0;
      r_drain   <= '0;
    end else begin
      // A strobe landing on the cycle its flag is consumed re-queues the channel.
      r_l_pend <= (r_l_pend && !(w_start && (w_start_chnl == CHNL_L))) || i_l_data_en;
      r_r_pend <= (r_r_pend && !(w_start && (w_start_chnl == CHNL_R))) || i_r_data_en;
      if ((i_l_data_en && (r_l_pend || w_l_serv)) || (i_r_data_en && (r_r_pend || w_r_serv))) begin
        r_overrun <= 1'b1;
      end
      if (w_start) r_chnl <= w_start_chnl;
      case (r_state)
        LOAD: begin
          r_taps_q <= (i_taps_per_filter == '0) ? TAP_AW'(1) : i_taps_per_filter;
          r_tap    <= '0;
          r_filt   <= '0;
        end
        MAC: begin
          r_tap   <= r_tap + TAP_AW'(1);
          r_drain <= '0;
        end
        DRAIN:   r_drain <= r_drain + DW'(1);
        STORE: begin
          r_tap <= '0;
          if (!w_filt_last) r_filt <= r_filt + FW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_SCHED_PERF_EN
  logic [15:0] r_job_cnt, r_max_job, w_cnt_now;

  assign w_cnt_now = (r_state == LOAD) ? 16'd1 :
                     ((r_job_cnt == 16'hFFFF) ? r_job_cnt : r_job_cnt + 16'd1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_job_cnt <= '0;
      r_max_job <= '0;
    end else if (!i_audio_en) begin
      r_job_cnt <= '0;
      r_max_job <= '0;
    end else begin
      if (r_state != IDLE) r_job_cnt <= w_cnt_now;
      if ((r_state == DONE) && (w_cnt_now > r_max_job)) r_max_job <= w_cnt_now;
    end
  end

  assign o_max_job_cycles = i_audio_en ? r_max_job : 16'd0;
`else
  assign o_max_job_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed job table plus hand sequences for wrap and abort; checks every issued control against a pointer/tap model.
module tb_fir_mac_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       audio_en = 1'b1;
  logic       l_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] taps = 8'd16;

  logic       chnl_sel, sample_wr, mac_clr, mac_en, acc_capture;
  logic       l_data_valid, r_data_valid, busy, overrun;
  logic [7:0] dl_addr;
  logic [9:0] coef_addr;
  logic [1:0] filter_idx;
  logic [15:0] max_job_cycles;

  int checks = 0;
  int failures = 0;
  int mptr[2];

  fir_mac_scheduler dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_audio_en        (audio_en),
    .i_taps_per_filter (taps),
    .i_l_data_en       (l_en),
    .i_r_data_en       (r_en),
    .o_chnl_sel        (chnl_sel),
    .o_sample_wr       (sample_wr),
    .o_dl_addr         (dl_addr),
    .o_coef_addr       (coef_addr),
    .o_mac_clr         (mac_clr),
    .o_mac_en          (mac_en),
    .o_acc_capture     (acc_capture),
    .o_filter_idx      (filter_idx),
    .o_l_data_valid    (l_data_valid),
    .o_r_data_valid    (r_data_valid),
    .o_busy            (busy),
    .o_overrun         (overrun),
    .o_max_job_cycles  (max_job_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Follows one job from its LOAD to its valid strobe, sampling on falling edges.
  task automatic run_job(input logic exp_ch, input int taps_eff, input int exp_pre,
                         input int hook_at, input logic [7:0] hook_taps, input logic hook_l,
                         output logic [7:0] wr_addr, output logic [7:0] dl_t1);
    int n = 0, pre = 0, macs = 0, clrs = 0, both = 0, caps = 0, bad = 0, ftr = 0, tp = 0;
    logic seen = 1'b0, done = 1'b0, ch_bad = 1'b0, wrong_v = 1'b0;
    logic [9:0] ecoef;
    wr_addr = 8'h00;
    dl_t1 = 8'h00;
    for (int cyc = 1; cyc <= 2000 && !done; cyc++) begin
      @(negedge clk);
      l_en = 1'b0;
      r_en = 1'b0;
      if (!seen) begin
        if (sample_wr) begin
          seen = 1'b1;
          pre = cyc;
          n = 1;
          wr_addr = dl_addr;
          if (chnl_sel !== exp_ch) ch_bad = 1'b1;
          mptr[exp_ch] = (mptr[exp_ch] + 1) % 256;
        end
      end else begin
        n++;
        if (hook_at != 0 && n == hook_at) begin
          if (hook_taps != 8'd0) taps = hook_taps;
          if (hook_l) l_en = 1'b1;
        end
        if (chnl_sel !== exp_ch) ch_bad = 1'b1;
        if (mac_clr) clrs++;
        if (mac_clr && mac_en) both++;
        if (mac_en) begin
          macs++;
          ecoef = 10'(ftr * 256 + tp);
          if (coef_addr !== ecoef) bad++;
          if (dl_addr !== 8'(mptr[exp_ch] - tp)) bad++;
          if (ftr == 0 && tp == 1) dl_t1 = dl_addr;
          tp++;
        end
        if (acc_capture) begin
          caps++;
          ftr++;
          tp = 0;
        end
        if (l_data_valid || r_data_valid) begin
          done = 1'b1;
          wrong_v = exp_ch ? l_data_valid : r_data_valid;
        end
      end
    end
    chk("load_seen", int'(seen), 1);
    chk("job_done", int'(done), 1);
    chk("load_delay", pre, exp_pre);
    chk("sample_wr_addr", int'(wr_addr), mptr[exp_ch]);
    chk("chnl_sel_const_bad", int'(ch_bad), 0);
    chk("mac_en_count", macs, 4 * taps_eff);
    chk("mac_clr_count", clrs, 4);
    chk("mac_clr_with_en", both, 4);
    chk("acc_capture_count", caps, 4);
    chk("addr_seq_errors", bad, 0);
    chk("job_length", n, 2 + 4 * (taps_eff + 3));
    chk("valid_wrong_chnl", int'(wrong_v), 0);
  endtask

  typedef struct {
    logic       l_en;
    logic       r_en;
    logic       clr_before;
    logic [7:0] taps;
    logic       exp_ch;
    int         taps_eff;
    int         exp_pre;
    int         hook_at;
    logic [7:0] hook_taps;
    logic       hook_l;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] wa, d1;
    int vcnt, bcnt;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd16, 1'b0, 16, 2, 0,  8'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd4,  1'b0, 4,  2, 0,  8'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'd4,  1'b1, 4,  1, 0,  8'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1,  2, 0,  8'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b0, 4,  2, 10, 8'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'd4,  1'b0, 4,  1, 0,  8'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'd8,  1'b0, 8,  2, 5,  8'd3, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'd3,  1'b0, 3,  2, 0,  8'd0, 1'b0, 1'b0};
    mptr[0] = 0;
    mptr[1] = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_sample_wr", int'(sample_wr), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_max_job", int'(max_job_cycles), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr_before) begin
        repeat (2) @(negedge clk);
        audio_en = 1'b0;
        @(negedge clk);
        chk("disabled_busy", int'(busy), 0);
        audio_en = 1'b1;
        mptr[0] = 0;
        mptr[1] = 0;
      end
      if (tbl[i].l_en || tbl[i].r_en) begin
        repeat (2) @(negedge clk);
        taps = tbl[i].taps;
        l_en = tbl[i].l_en;
        r_en = tbl[i].r_en;
      end
      run_job(tbl[i].exp_ch, tbl[i].taps_eff, tbl[i].exp_pre, tbl[i].hook_at,
              tbl[i].hook_taps, tbl[i].hook_l, wa, d1);
      chk("overrun_after_job", int'(overrun), int'(tbl[i].exp_ovr));
    end
`ifdef FIR_SCHED_PERF_EN
    chk("max_job_cycles", int'(max_job_cycles), 46);
`else
    chk("max_job_cycles_tied", int'(max_job_cycles), 0);
`endif

    // Wrap: after a clear, the 256th left job lands its sample at address 0.
    repeat (2) @(negedge clk);
    audio_en = 1'b0;
    @(negedge clk);
    audio_en = 1'b1;
    mptr[0] = 0;
    mptr[1] = 0;
    for (int j = 0; j < 256; j++) begin
      repeat (2) @(negedge clk);
      taps = 8'd2;
      l_en = 1'b1;
      run_job(1'b0, 2, 2, 0, 8'd0, 1'b0, wa, d1);
    end
    chk("wrap_wr_addr", int'(wa), 0);
    chk("wrap_tap1_dl_addr", int'(d1), 255);

    // Abort mid-job: no valid strobe may follow and the block must be idle.
    repeat (2) @(negedge clk);
    taps = 8'd16;
    l_en = 1'b1;
    @(negedge clk);
    l_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    audio_en = 1'b0;
    @(negedge clk);
    chk("abort_mac_en", int'(mac_en), 0);
    audio_en = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (l_data_valid || r_data_valid) vcnt++;
      if (busy) bcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_stays_idle", bcnt, 0);
    chk("abort_overrun", int'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
